// File: rtl/bus_dma_master.sv
// bus_dma_master: bus initiator that copies LEN 32-bit words from src to dst over the shared system bus.
// Latency: 1 (REQ) + 2 cycles/word + 1 (FIN) after start under continuous grant; a fill word takes 1 cycle.
// Backpressure: bus_gnt low parks the FSM in REQ; a buffered copy word waits in WR until grant returns.
// Optional feature macro: DMA_FILL_EN (adds fill/fill_data inputs; fill=1 writes fill_data, skipping reads).
// Ports: clk/rst_n (async active-low); start/src_addr/dst_addr/len request; busy/done status;
//        bus_req/bus_gnt arbitration; write/writedata/address/readdata system bus pins.
module bus_dma_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
`endif
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] readdata
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] data_buf;
  logic              fill_mode;
  logic [DATA_W-1:0] wr_word;

`ifdef DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= 1'b0;
      fill_dat_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q     <= fill;
      fill_dat_q <= fill_data;
    end
  end

  assign fill_mode = fill_q;
  assign wr_word   = fill_q ? fill_dat_q : data_buf;
`else
  assign fill_mode = 1'b0;
  assign wr_word   = data_buf;
`endif

  // Next state and all outputs; bus pins are only driven while the grant is held.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == FIN);
    bus_req   = (state == REQ) || (state == RD) || (state == WR);
    write     = 1'b0;
    address   = '0;
    writedata = '0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? FIN : REQ;
      end
      REQ: begin
        if (bus_gnt) state_nxt = fill_mode ? WR : RD;
      end
      RD: begin
        // Grant lost on entry to RD: no read is issued, go back and wait.
        if (bus_gnt) begin
          address   = src;
          state_nxt = WR;
        end else begin
          state_nxt = REQ;
        end
      end
      WR: begin
        if (bus_gnt) begin
          address   = dst;
          write     = 1'b1;
          writedata = wr_word;
          if (count == LEN_W'(1)) state_nxt = FIN;
          else                    state_nxt = fill_mode ? WR : RD;
        end else if (fill_mode) begin
          // Nothing is in flight for a fill word, so it is safe to park in REQ.
          // A copy word sits in data_buf and must stay in WR so it is never split.
          state_nxt = REQ;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      count    <= '0;
      data_buf <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        src   <= src_addr;
        dst   <= dst_addr;
        count <= len;
      end
      if (state == RD && bus_gnt) begin
        data_buf <= readdata;
        src      <= src + ADDR_W'(4);  // wraps modulo 2^ADDR_W
      end
      if (state == WR && bus_gnt) begin
        dst   <= dst + ADDR_W'(4);
        count <= count - LEN_W'(1);
      end
    end
  end

endmodule
